conv_window_ctrl: RTL and testbench

Sequencer for the 3x3 sliding-window line FIFO in the convolution datapath.
- Accepts a pixel stream over a valid/ready handshake and drives the FIFO write enable.
- Issues FIFO reads only once enough pixels are buffered for a full window.
- Discards the row-wrap windows and presents valid windows downstream with row/column tags.
- Pulses done after the last window of a frame is accepted.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_pos_counter.sv | 33 +++
 rtl/conv_window_ctrl.sv | 151 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution window sequencer.
// State encoding, window geometry and default widths.
package conv_pkg;

   localparam int ADDR_BIT_DEF = 5;
   localparam int DIM_BIT_DEF  = 8;

   // Pixels buffered beyond two full rows before a window is complete
   localparam int NEED_OFS = 3;
   // Window edge length; the last WIN_SIZE-1 columns of a row are wrap windows
   localparam int WIN_SIZE = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Row/column position counter: column wraps at col_lim and carries into row.
// Synchronous clear restarts both at (0,0).
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int COL_BIT = ADDR_BIT_DEF,
   parameter int ROW_BIT = DIM_BIT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [COL_BIT-1:0] col_lim,
   output logic [COL_BIT-1:0] col,
   output logic [ROW_BIT-1:0] row
);

   // Advance column on enable; wrap to 0 and bump row at the last column
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col == col_lim) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the 3x3 sliding-window line FIFO.
// Optional stall counter enabled by CONV_WINDOW_CTRL_PERF_EN.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int ADDR_BIT = ADDR_BIT_DEF,
   parameter int DIM_BIT  = DIM_BIT_DEF,
   parameter int CNT_BIT  = ADDR_BIT + DIM_BIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_BIT-1:0] row_len,
   input  logic [DIM_BIT-1:0]  col_len,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic                fifo_wen,
   output logic                fifo_ren,
   input  logic                fifo_full,
   input  logic                fifo_empty,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [DIM_BIT-1:0]  win_row,
   output logic [ADDR_BIT-1:0] win_col,
   output logic                busy,
`ifdef CONV_WINDOW_CTRL_PERF_EN
   output logic [15:0]         stall_cnt,
`endif
   output logic                done
);

   state_t              state;
   logic [ADDR_BIT-1:0] r_len;
   logic [CNT_BIT-1:0]  total;
   logic [CNT_BIT-1:0]  nread;
   logic [CNT_BIT-1:0]  need;
   logic [CNT_BIT-1:0]  wr_cnt;
   logic [CNT_BIT-1:0]  rd_cnt;
   logic [ADDR_BIT-1:0] col;
   logic [DIM_BIT-1:0]  row;

   logic [CNT_BIT-1:0]  row_ext;
   logic [CNT_BIT-1:0]  col_ext;
   logic [ADDR_BIT-1:0] col_lim;
   logic                start_ok;
   logic                active;
   logic                wr_done;
   logic                avail;
   logic                keep;
   logic                drain_go;

   assign row_ext  = CNT_BIT'(row_len);
   assign col_ext  = CNT_BIT'(col_len);
   assign col_lim  = r_len - ADDR_BIT'(1);
   assign start_ok = (state == IDLE) && start;
   assign active   = (state == RUN) || (state == DRAIN);
   assign wr_done  = (wr_cnt == total);
   assign busy     = (state != IDLE);

   assign pix_ready = active && (wr_cnt < total) && !fifo_full;
   assign fifo_wen  = pix_valid && pix_ready;

   // Either a full window is buffered or the frame tail is all in the FIFO
   assign avail = ((wr_cnt - rd_cnt) >= need) || wr_done;

   // Never read over a window the consumer has not taken yet
   assign fifo_ren = (state == RUN) && avail && (rd_cnt < nread)
                     && !fifo_empty && (!win_valid || win_ready);

   // The last two columns of each row form wrap-around windows
   assign keep     = col < (r_len - ADDR_BIT'(WIN_SIZE - 1));
   assign drain_go = !win_valid || win_ready;

   conv_pos_counter #(
      .COL_BIT (ADDR_BIT),
      .ROW_BIT (DIM_BIT)
   ) u_pos (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_ok),
      .en      (fifo_ren),
      .col_lim (col_lim),
      .col     (col),
      .row     (row)
   );

   // Frame FSM, pixel counters and registered window tags
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         r_len     <= '0;
         total     <= '0;
         nread     <= '0;
         need      <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fifo_wen)
            wr_cnt <= wr_cnt + 1'b1;
         if (fifo_ren) begin
            rd_cnt    <= rd_cnt + 1'b1;
            win_valid <= keep;
            win_row   <= row;
            win_col   <= col;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  r_len  <= row_len;
                  total  <= row_ext * col_ext;
                  nread  <= row_ext * (col_ext - CNT_BIT'(WIN_SIZE - 1));
                  need   <= (row_ext << 1) + CNT_BIT'(NEED_OFS);
                  wr_cnt <= '0;
                  rd_cnt <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if ((rd_cnt == nread) && wr_done)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (drain_go) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CONV_WINDOW_CTRL_PERF_EN
   // Saturating count of RUN cycles where a read was due but did not issue
   always_ff @(posedge clk) begin
      if (rst || start_ok)
         stall_cnt <= '0;
      else if ((state == RUN) && avail && !fifo_ren && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed testbench for conv_window_ctrl with a behavioural FIFO flag model.
// Each scenario task drives one frame and checks its own results.
module tb_conv_window_ctrl;

   localparam int AB = 5;
   localparam int DB = 8;

   typedef int q_t[$];

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AB-1:0] row_len;
   logic [DB-1:0] col_len;
   logic          pix_valid;
   logic          pix_ready;
   logic          fifo_wen;
   logic          fifo_ren;
   logic          fifo_full;
   logic          fifo_empty;
   logic          win_valid;
   logic          win_ready;
   logic [DB-1:0] win_row;
   logic [AB-1:0] win_col;
   logic          busy;
   logic          done;
`ifdef CONV_WINDOW_CTRL_PERF_EN
   logic [15:0]   stall_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   int occ;
   bit force_full;
   int wr_seen, rd_seen, first_ren_wr;
   int avail_viol, stall_viol, stall_seen, full_viol, full_cycles;
   int done_cnt, done_cyc, last_win_cyc;
   q_t got;
   q_t exp;

   always #5 clk = ~clk;

   conv_window_ctrl #(
      .ADDR_BIT (AB),
      .DIM_BIT  (DB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .row_len    (row_len),
      .col_len    (col_len),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .fifo_wen   (fifo_wen),
      .fifo_ren   (fifo_ren),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .busy       (busy),
`ifdef CONV_WINDOW_CTRL_PERF_EN
      .stall_cnt  (stall_cnt),
`endif
      .done       (done)
   );

   // Expected (row,col) tags, encoded row*256+col, in acceptance order
   function automatic q_t exp_tags(input int r, input int c);
      q_t q;
      for (int rr = 0; rr < c - 2; rr++)
         for (int cc = 0; cc < r - 2; cc++)
            q.push_back(rr * 256 + cc);
      return q;
   endfunction

   // One-cycle reset of DUT and the FIFO model
   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      occ = 0;
   endtask

   // Drive one frame; records observations, makes no comparisons
   task automatic run_frame(input int r, input int c, input int vmode,
                            input int rmode, input int full_from,
                            input int full_to, input int mid_start,
                            input int abort_win, input int need);
      bit prev_stall;
      int pr, pc;
      pulse_rst();
      wr_seen = 0; rd_seen = 0; first_ren_wr = -1;
      avail_viol = 0; stall_viol = 0; stall_seen = 0;
      full_viol = 0; full_cycles = 0;
      done_cnt = 0; done_cyc = -1; last_win_cyc = -1;
      got.delete();
      prev_stall = 1'b0; pr = 0; pc = 0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         start = (k == 0) || (k == mid_start);
         row_len = (k == 0) ? r[AB-1:0] : 5'd7;
         col_len = c[DB-1:0];
         pix_valid = (vmode == 0) || (k % 3 == 0);
         win_ready = (rmode == 0) || (k % 4 == 0) || (k % 4 == 3);
         force_full = (k >= full_from) && (k < full_to);
         fifo_full = force_full || (occ >= 32);
         fifo_empty = (occ == 0);
         @(negedge clk);
         if (prev_stall && (!win_valid || int'(win_row) != pr
                            || int'(win_col) != pc))
            stall_viol++;
         prev_stall = win_valid && !win_ready;
         pr = int'(win_row);
         pc = int'(win_col);
         if (prev_stall) begin
            stall_seen++;
            if (fifo_ren) stall_viol++;
         end
         if (force_full) begin
            full_cycles++;
            if (pix_ready || fifo_wen) full_viol++;
         end
         if (fifo_ren) begin
            if (first_ren_wr < 0) first_ren_wr = wr_seen;
            if (wr_seen < r * c && wr_seen - rd_seen < need) avail_viol++;
            rd_seen++;
         end
         if (fifo_wen) wr_seen++;
         occ = occ + int'(fifo_wen) - int'(fifo_ren);
         if (win_valid && win_ready) begin
            got.push_back(int'(win_row) * 256 + int'(win_col));
            last_win_cyc = k;
         end
         if (done) begin
            done_cnt++;
            done_cyc = k;
         end
         if (done || got.size() == abort_win) break;
      end
      start = 1'b0;
      force_full = 1'b0;
   endtask

   task automatic test_reset();
      pix_valid = 1'b1; win_ready = 1'b1; start = 1'b0;
      row_len = 5'd5; col_len = 8'd5;
      fifo_full = 1'b0; fifo_empty = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (pix_ready !== 1'b0) begin miscompares++;
         $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
      vectors++; if (fifo_wen !== 1'b0) begin miscompares++;
         $display("FAIL reset_fifo_wen got %b want 0", fifo_wen); end
      vectors++; if (fifo_ren !== 1'b0) begin miscompares++;
         $display("FAIL reset_fifo_ren got %b want 0", fifo_ren); end
      vectors++; if (win_valid !== 1'b0) begin miscompares++;
         $display("FAIL reset_win_valid got %b want 0", win_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++;
         $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++;
         $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (win_row !== 8'd0) begin miscompares++;
         $display("FAIL reset_win_row got %0d want 0", win_row); end
      vectors++; if (win_col !== 5'd0) begin miscompares++;
         $display("FAIL reset_win_col got %0d want 0", win_col); end
      rst = 1'b0;
      occ = 0;
   endtask

   task automatic test_basic();
      run_frame(5, 5, 0, 0, -1, -1, -1, -1, 13);
      exp = exp_tags(5, 5);
      vectors++; if (wr_seen !== 25) begin miscompares++;
         $display("FAIL basic_writes got %0d want 25", wr_seen); end
      vectors++; if (rd_seen !== 15) begin miscompares++;
         $display("FAIL basic_reads got %0d want 15", rd_seen); end
      vectors++; if (first_ren_wr !== 13) begin miscompares++;
         $display("FAIL basic_first_ren got wr=%0d want 13", first_ren_wr); end
      vectors++; if (avail_viol !== 0) begin miscompares++;
         $display("FAIL basic_avail got %0d early reads want 0", avail_viol); end
      vectors++; if (got.size() !== 9) begin miscompares++;
         $display("FAIL basic_win_count got %0d want 9", got.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp[i]) begin miscompares++;
            $display("FAIL basic_tag[%0d] got %0h want %0h", i, got[i], exp[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++;
         $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
      vectors++; if ((done_cyc > last_win_cyc) !== 1'b1) begin miscompares++;
         $display("FAIL basic_done_order got done@%0d win@%0d want done later",
                  done_cyc, last_win_cyc); end
      @(posedge clk); #1;
      vectors++; if (busy !== 1'b0) begin miscompares++;
         $display("FAIL basic_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      run_frame(5, 5, 0, 1, -1, -1, -1, -1, 13);
      exp = exp_tags(5, 5);
      vectors++; if ((stall_seen > 0) !== 1'b1) begin miscompares++;
         $display("FAIL bp_stall_seen got %0d want >0", stall_seen); end
      vectors++; if (stall_viol !== 0) begin miscompares++;
         $display("FAIL bp_hold got %0d violations want 0", stall_viol); end
      vectors++; if (got.size() !== 9) begin miscompares++;
         $display("FAIL bp_win_count got %0d want 9", got.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp[i]) begin miscompares++;
            $display("FAIL bp_tag[%0d] got %0h want %0h", i, got[i], exp[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++;
         $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_pix_gaps();
      run_frame(5, 5, 1, 0, -1, -1, -1, -1, 13);
      exp = exp_tags(5, 5);
      vectors++; if (avail_viol !== 0) begin miscompares++;
         $display("FAIL gap_avail got %0d early reads want 0", avail_viol); end
      vectors++; if (first_ren_wr !== 13) begin miscompares++;
         $display("FAIL gap_first_ren got wr=%0d want 13", first_ren_wr); end
      vectors++; if (rd_seen !== 15) begin miscompares++;
         $display("FAIL gap_reads got %0d want 15", rd_seen); end
      vectors++; if (got.size() !== 9) begin miscompares++;
         $display("FAIL gap_win_count got %0d want 9", got.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp[i]) begin miscompares++;
            $display("FAIL gap_tag[%0d] got %0h want %0h", i, got[i], exp[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++;
         $display("FAIL gap_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_wide_row();
      run_frame(10, 3, 0, 0, 4, 9, -1, -1, 23);
      exp = exp_tags(10, 3);
      vectors++; if (full_cycles !== 5) begin miscompares++;
         $display("FAIL wide_full_cycles got %0d want 5", full_cycles); end
      vectors++; if (full_viol !== 0) begin miscompares++;
         $display("FAIL wide_full_block got %0d writes want 0", full_viol); end
      vectors++; if (first_ren_wr !== 23) begin miscompares++;
         $display("FAIL wide_first_ren got wr=%0d want 23", first_ren_wr); end
      vectors++; if (wr_seen !== 30) begin miscompares++;
         $display("FAIL wide_writes got %0d want 30", wr_seen); end
      vectors++; if (rd_seen !== 10) begin miscompares++;
         $display("FAIL wide_reads got %0d want 10", rd_seen); end
      vectors++; if (got.size() !== 8) begin miscompares++;
         $display("FAIL wide_win_count got %0d want 8", got.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp[i]) begin miscompares++;
            $display("FAIL wide_tag[%0d] got %0h want %0h", i, got[i], exp[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++;
         $display("FAIL wide_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_abort();
      run_frame(5, 5, 0, 0, -1, -1, -1, 7, 13);
      vectors++; if (got.size() !== 7) begin miscompares++;
         $display("FAIL abort_win_count got %0d want 7", got.size()); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++;
         $display("FAIL abort_pre_done got %b want 0", done); end
      @(posedge clk); #1;
      occ = 0;
      fifo_empty = 1'b1;
      fifo_full = 1'b0;
      vectors++; if ({win_valid, busy, done, pix_ready, fifo_wen, fifo_ren}
                     !== 6'b0) begin miscompares++;
         $display("FAIL abort_outputs got v%b b%b d%b pr%b w%b r%b want 0",
                  win_valid, busy, done, pix_ready, fifo_wen, fifo_ren); end
      vectors++; if ({win_row, win_col} !== 13'd0) begin miscompares++;
         $display("FAIL abort_tags got %0d,%0d want 0,0", win_row, win_col); end
      rst = 1'b0;
      done_cnt = done_cnt + int'(done);
      vectors++; if (done_cnt !== 0) begin miscompares++;
         $display("FAIL abort_no_done got %0d want 0", done_cnt); end
      run_frame(5, 5, 0, 0, -1, -1, -1, -1, 13);
      exp = exp_tags(5, 5);
      vectors++; if (got.size() !== 9) begin miscompares++;
         $display("FAIL restart_win_count got %0d want 9", got.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp[i]) begin miscompares++;
            $display("FAIL restart_tag[%0d] got %0h want %0h", i, got[i], exp[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++;
         $display("FAIL restart_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_busy();
      run_frame(5, 5, 0, 0, -1, -1, 6, -1, 13);
      exp = exp_tags(5, 5);
      vectors++; if (wr_seen !== 25) begin miscompares++;
         $display("FAIL sbusy_writes got %0d want 25", wr_seen); end
      vectors++; if (got.size() !== 9) begin miscompares++;
         $display("FAIL sbusy_win_count got %0d want 9", got.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp[i]) begin miscompares++;
            $display("FAIL sbusy_tag[%0d] got %0h want %0h", i, got[i], exp[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++;
         $display("FAIL sbusy_done_cnt got %0d want 1", done_cnt); end
   endtask

   initial begin
      occ = 0;
      force_full = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_pix_gaps();
      test_wide_row();
      test_abort();
      test_start_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
